ghostbus_arb: RTL and testbench

Two-requester arbiter that shares one ghostbus host port (gb_addr/gb_dout/gb_din/gb_we) between two independent host masters, e.g. a UART/JTAG bridge and an on-chip sequencer. It sits between the masters and the top-level ghostbus-decoded hierarchy. It serialises their single-word read/write transactions with round-robin fairness. It handles the fixed registered read latency of the decoded peripherals.

---
 rtl/ghostbus_arb_pkg.sv | 15 +
 rtl/ghostbus_rr_pick.sv | 26 ++
 rtl/ghostbus_arb.sv | 162 ++++++++++++++++
 tb/tb_ghostbus_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghostbus_arb_pkg.sv
// ghostbus_arb_pkg: FSM state encoding and master-index type shared by the
// ghostbus two-master arbiter and its round-robin picker.
package ghostbus_arb_pkg;

    localparam int IDX_W = 1;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } gb_state_e;

endpackage

// File: rtl/ghostbus_rr_pick.sv
// ghostbus_rr_pick: combinational 2-way round-robin choice; a held lock lets
// the last-granted master win again whenever it is requesting.
module ghostbus_rr_pick
    import ghostbus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  idx_t       last,
    input  logic       lock_hold,
    output logic       gnt_valid,
    output idx_t       gnt_idx
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        gnt_valid = |req;
        gnt_idx   = '0;
        if (lock_hold && req[last]) begin
            gnt_idx = last;
        end else if (&req) begin
            gnt_idx = ~last;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule

// File: rtl/ghostbus_arb.sv
// ghostbus_arb: serialises single-word transactions from two masters onto one
// ghostbus host port. Define GHOSTBUS_ARB_LOCK_EN to add the mX_lock grant hold.
module ghostbus_arb
    import ghostbus_arb_pkg::*;
#(
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int READ_LAT = 1
) (
    input  logic          gb_clk,
    input  logic          gb_rstn,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
`ifdef GHOSTBUS_ARB_LOCK_EN
    input  logic          m0_lock,
`endif

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
`ifdef GHOSTBUS_ARB_LOCK_EN
    input  logic          m1_lock,
`endif

    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_dout,
    output logic          gb_we,
    input  logic [DW-1:0] gb_din,
    output logic          busy,
    output logic          grant
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

    gb_state_e      state_q;
    idx_t           ptr_q;
    idx_t           grant_q;
    logic           lock_hold_q;
    logic           we_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]  gb_addr_q;
    logic [DW-1:0]  gb_dout_q;
    logic           gb_we_q;
    logic [1:0]     ack_q;
    logic [DW-1:0]  rdata0_q;
    logic [DW-1:0]  rdata1_q;
    logic           busy_q;

    logic           gnt_valid;
    idx_t           gnt_idx;
    logic           lock_sel;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;

`ifdef GHOSTBUS_ARB_LOCK_EN
    assign lock_sel = grant_q[0] ? m1_lock : m0_lock;
`else
    assign lock_sel = 1'b0;
`endif

    ghostbus_rr_pick u_pick (
        .req       ({m1_req, m0_req}),
        .last      (ptr_q),
        .lock_hold (lock_hold_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (gnt_idx[0]) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    always_ff @(posedge gb_clk) begin
        if (!gb_rstn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= idx_t'(1);
            grant_q     <= '0;
            lock_hold_q <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            gb_addr_q   <= '0;
            gb_dout_q   <= '0;
            gb_we_q     <= 1'b0;
            ack_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: ack defaults low every cycle, so it can only be a one-cycle pulse.
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        grant_q   <= gnt_idx;
                        ptr_q     <= gnt_idx;
                        we_q      <= sel_we;
                        gb_we_q   <= sel_we;
                        gb_addr_q <= sel_addr;
                        gb_dout_q <= sel_wdata;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gb_we_q <= 1'b0;
                    cnt_q   <= CNT_INIT;
                    if (we_q) begin
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // gb_din is valid at the edge that ends the last WAIT cycle.
                    if (cnt_q == '0) begin
                        if (grant_q[0]) rdata1_q <= gb_din;
                        else            rdata0_q <= gb_din;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    lock_hold_q <= lock_sel;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gb_addr  = gb_addr_q;
    assign gb_dout  = gb_dout_q;
    assign gb_we    = gb_we_q;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign busy     = busy_q;
    assign grant    = grant_q[0];

endmodule

// File: tb/tb_ghostbus_arb.sv
// tb_ghostbus_arb: directed bench for ghostbus_arb with two instances
// (READ_LAT = 1 and READ_LAT = 3), each driving a small RAM model.
module tb_ghostbus_arb;

    localparam int AW = 24;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic          a_rstn, a_m0_req, a_m0_we, a_m0_ack, a_m1_req, a_m1_we, a_m1_ack;
    logic [AW-1:0] a_m0_addr, a_m1_addr, a_gb_addr;
    logic [DW-1:0] a_m0_wdata, a_m0_rdata, a_m1_wdata, a_m1_rdata, a_gb_dout, a_gb_din;
    logic          a_gb_we, a_busy, a_grant;
`ifdef GHOSTBUS_ARB_LOCK_EN
    logic          a_m0_lock, a_m1_lock, b_m0_lock, b_m1_lock;
`endif

    logic          b_rstn, b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack;
    logic [AW-1:0] b_m0_addr, b_m1_addr, b_gb_addr;
    logic [DW-1:0] b_m0_wdata, b_m0_rdata, b_m1_wdata, b_m1_rdata, b_gb_dout, b_gb_din;
    logic          b_gb_we, b_busy, b_grant;

    ghostbus_arb #(.AW(AW), .DW(DW), .READ_LAT(1)) dut_a (
        .gb_clk(clk), .gb_rstn(a_rstn),
        .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
`ifdef GHOSTBUS_ARB_LOCK_EN
        .m0_lock(a_m0_lock),
`endif
        .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
`ifdef GHOSTBUS_ARB_LOCK_EN
        .m1_lock(a_m1_lock),
`endif
        .gb_addr(a_gb_addr), .gb_dout(a_gb_dout), .gb_we(a_gb_we), .gb_din(a_gb_din),
        .busy(a_busy), .grant(a_grant)
    );

    ghostbus_arb #(.AW(AW), .DW(DW), .READ_LAT(3)) dut_b (
        .gb_clk(clk), .gb_rstn(b_rstn),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
`ifdef GHOSTBUS_ARB_LOCK_EN
        .m0_lock(b_m0_lock),
`endif
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
`ifdef GHOSTBUS_ARB_LOCK_EN
        .m1_lock(b_m1_lock),
`endif
        .gb_addr(b_gb_addr), .gb_dout(b_gb_dout), .gb_we(b_gb_we), .gb_din(b_gb_din),
        .busy(b_busy), .grant(b_grant)
    );

    // RAM models: one registered read stage for A, three for B.
    logic [DW-1:0] mem_a [0:1023];
    logic [DW-1:0] mem_b [0:1023];
    logic [DW-1:0] b_s1, b_s2;

    always @(posedge clk) begin
        if (a_gb_we) mem_a[a_gb_addr[9:0]] <= a_gb_dout;
        a_gb_din <= mem_a[a_gb_addr[9:0]];
    end

    always @(posedge clk) begin
        if (b_gb_we) mem_b[b_gb_addr[9:0]] <= b_gb_dout;
        b_s1     <= mem_b[b_gb_addr[9:0]];
        b_s2     <= b_s1;
        b_gb_din <= b_s2;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input int m, input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (m == 0) begin
            a_m0_req = req; a_m0_we = we; a_m0_addr = addr; a_m0_wdata = wd;
        end else begin
            a_m1_req = req; a_m1_we = we; a_m1_addr = addr; a_m1_wdata = wd;
        end
    endtask

    task automatic b_drive(input int m, input logic req, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        if (m == 0) begin
            b_m0_req = req; b_m0_we = we; b_m0_addr = addr; b_m0_wdata = wd;
        end else begin
            b_m1_req = req; b_m1_we = we; b_m1_addr = addr; b_m1_wdata = wd;
        end
    endtask

    task automatic a_reset();
        a_rstn = 1'b0;
        a_drive(0, 1'b0, 1'b0, '0, '0);
        a_drive(1, 1'b0, 1'b0, '0, '0);
`ifdef GHOSTBUS_ARB_LOCK_EN
        a_m0_lock = 1'b0;
        a_m1_lock = 1'b0;
`endif
        tick();
        tick();
        a_rstn = 1'b1;
    endtask

    // One transaction on instance A; latency counted in cycles from request.
    task automatic a_xact(input string tag, input int m, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int exp_n, input logic [DW-1:0] exp_rd);
        int            n     = 0;
        logic          other = 1'b0;
        logic [DW-1:0] rd    = '0;
        a_drive(m, 1'b1, we, addr, wd);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((m == 0) ? a_m0_ack : a_m1_ack) begin
                n     = i;
                other = (m == 0) ? a_m1_ack : a_m0_ack;
                rd    = (m == 0) ? a_m0_rdata : a_m1_rdata;
                break;
            end
        end
        a_drive(m, 1'b0, 1'b0, '0, '0);
        check({tag, "_lat"}, 64'(n), 64'(exp_n));
        check({tag, "_other_ack"}, 64'(other), 64'd0);
        if (!we) check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
        tick();
        check({tag, "_idle"}, 64'(a_busy), 64'd0);
    endtask

    task automatic b_wr(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n = 0;
        b_drive(0, 1'b1, 1'b1, addr, wd);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (b_m0_ack) begin
                n = i;
                break;
            end
        end
        b_drive(0, 1'b0, 1'b0, '0, '0);
        check({tag, "_lat"}, 64'(n), 64'd2);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int            t0, t1, both, acks, tlast, bad, we_seen, seq;
        logic [DW-1:0] rd0, rd1;
        int            order[$];

        a_rstn = 1'b0;
        b_rstn = 1'b0;
        a_drive(0, 1'b0, 1'b0, '0, '0);
        a_drive(1, 1'b0, 1'b0, '0, '0);
        b_drive(0, 1'b0, 1'b0, '0, '0);
        b_drive(1, 1'b0, 1'b0, '0, '0);
`ifdef GHOSTBUS_ARB_LOCK_EN
        a_m0_lock = 1'b0; a_m1_lock = 1'b0; b_m0_lock = 1'b0; b_m1_lock = 1'b0;
`endif
        tick(); tick(); tick();
        check("rst_gb_we", 64'(a_gb_we), 64'd0);
        check("rst_acks", 64'({a_m1_ack, a_m0_ack}), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_grant", 64'(a_grant), 64'd0);
        a_rstn = 1'b1;
        b_rstn = 1'b1;

        // Cycle-accurate m0 write.
        a_drive(0, 1'b1, 1'b1, 24'h000001, 32'hCECEFACE);
        tick();
        check("wr_issue_we", 64'(a_gb_we), 64'd1);
        check("wr_issue_addr", 64'(a_gb_addr), 64'h1);
        check("wr_issue_dout", 64'(a_gb_dout), 64'hCECEFACE);
        check("wr_issue_busy", 64'(a_busy), 64'd1);
        check("wr_issue_ack", 64'(a_m0_ack), 64'd0);
        tick();
        check("wr_done_ack", 64'({a_m1_ack, a_m0_ack}), 64'b01);
        check("wr_done_we", 64'(a_gb_we), 64'd0);
        a_drive(0, 1'b0, 1'b0, '0, '0);
        tick();
        check("wr_idle_ack", 64'(a_m0_ack), 64'd0);
        check("wr_idle_busy", 64'(a_busy), 64'd0);

        a_xact("rd_001", 0, 1'b0, 24'h000001, '0, 3, 32'hCECEFACE);
        a_xact("wr_002", 1, 1'b1, 24'h000002, 32'h22222222, 2, '0);
        check("last_grant_m1", 64'(a_grant), 64'd1);

        // Simultaneous reads after reset: m0 first, m1 right after.
        a_reset();
        check("rst2_grant", 64'(a_grant), 64'd0);
        a_drive(0, 1'b1, 1'b0, 24'h000001, '0);
        a_drive(1, 1'b1, 1'b0, 24'h000002, '0);
        t0 = 0; t1 = 0; both = 0; rd0 = '0; rd1 = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (a_m0_ack && a_m1_ack) both++;
            if (a_m0_ack && t0 == 0) begin
                t0 = i; rd0 = a_m0_rdata; a_drive(0, 1'b0, 1'b0, '0, '0);
            end
            if (a_m1_ack && t1 == 0) begin
                t1 = i; rd1 = a_m1_rdata; a_drive(1, 1'b0, 1'b0, '0, '0);
            end
        end
        check("sim_m0_lat", 64'(t0), 64'd3);
        check("sim_m1_lat", 64'(t1), 64'd7);
        check("sim_m0_rdata", 64'(rd0), 64'hCECEFACE);
        check("sim_m1_rdata", 64'(rd1), 64'h22222222);
        check("sim_both_ack", 64'(both), 64'd0);

        // Both writes held continuously: grants alternate every 3 cycles.
        a_drive(0, 1'b1, 1'b1, 24'h000010, 32'h000000A0);
        a_drive(1, 1'b1, 1'b1, 24'h000011, 32'h000000B1);
        order.delete();
        tlast = 0;
        for (int i = 1; i <= 30 && order.size() < 4; i++) begin
            tick();
            if (a_m0_ack) order.push_back(0);
            if (a_m1_ack) order.push_back(1);
            if (a_m0_ack || a_m1_ack) tlast = i;
        end
        a_drive(0, 1'b0, 1'b0, '0, '0);
        a_drive(1, 1'b0, 1'b0, '0, '0);
        seq = 0;
        foreach (order[k]) seq = seq * 2 + order[k];
        check("alt_count", 64'(order.size()), 64'd4);
        check("alt_order", 64'(seq), 64'b0101);
        check("alt_last_cycle", 64'(tlast), 64'd11);
        tick();
        a_xact("rd_010", 0, 1'b0, 24'h000010, '0, 3, 32'h000000A0);
        a_xact("rd_011", 1, 1'b0, 24'h000011, '0, 3, 32'h000000B1);

        // Write then read with req held across the ack.
        a_drive(0, 1'b1, 1'b1, 24'h000020, 32'h12345678);
        acks = 0; t0 = 0; t1 = 0; rd0 = '0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (a_m0_ack) begin
                acks++;
                if (t0 == 0) begin
                    t0 = i; a_m0_we = 1'b0;
                end else begin
                    t1 = i; rd0 = a_m0_rdata; a_m0_req = 1'b0;
                end
            end
        end
        check("hold_acks", 64'(acks), 64'd2);
        check("hold_wr_lat", 64'(t0), 64'd2);
        check("hold_rd_lat", 64'(t1), 64'd6);
        check("hold_rdata", 64'(rd0), 64'h12345678);

        // Reset during WAIT aborts the read.
        a_drive(0, 1'b1, 1'b0, 24'h000020, '0);
        tick();
        tick();
        check("rw_busy_in_wait", 64'(a_busy), 64'd1);
        a_rstn = 1'b0;
        tick();
        check("rw_ack", 64'(a_m0_ack), 64'd0);
        check("rw_gb_we", 64'(a_gb_we), 64'd0);
        check("rw_busy", 64'(a_busy), 64'd0);
        check("rw_gb_addr", 64'(a_gb_addr), 64'd0);
        a_rstn = 1'b1;
        a_drive(0, 1'b0, 1'b0, '0, '0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_m0_ack) acks++;
        end
        check("rw_no_late_ack", 64'(acks), 64'd0);
        a_xact("post_rst_wr", 0, 1'b1, 24'h000030, 32'h00000055, 2, '0);

`ifdef GHOSTBUS_ARB_LOCK_EN
        // m0 holds the grant with lock while m1 waits.
        a_reset();
        a_m0_lock = 1'b1;
        a_drive(0, 1'b1, 1'b1, 24'h000040, 32'h1);
        a_drive(1, 1'b1, 1'b1, 24'h000041, 32'h2);
        order.delete();
        t0 = 0;
        for (int i = 1; i <= 40 && order.size() < 4; i++) begin
            tick();
            if (a_m0_ack) begin
                order.push_back(0);
                t0++;
                if (t0 == 3) begin
                    a_m0_lock = 1'b0;
                    a_m0_req  = 1'b0;
                end
            end
            if (a_m1_ack) begin
                order.push_back(1);
                a_m1_req = 1'b0;
            end
        end
        seq = 0;
        foreach (order[k]) seq = seq * 2 + order[k];
        check("lock_count", 64'(order.size()), 64'd4);
        check("lock_order", 64'(seq), 64'b0001);
        tick();
`endif

        // READ_LAT = 3 instance: m1 read of 0x100.
        b_wr("b_wr_100", 24'h000100, 32'h0000005A);
        b_wr("b_wr_0ff", 24'h0000FF, 32'h00000077);
        b_drive(1, 1'b1, 1'b0, 24'h000100, '0);
        t1 = 0; bad = 0; we_seen = 0; rd1 = '0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (b_gb_we) we_seen++;
            if (b_gb_addr != 24'h000100) bad++;
            if (b_m1_ack) begin
                t1 = i; rd1 = b_m1_rdata;
                break;
            end
        end
        b_drive(1, 1'b0, 1'b0, '0, '0);
        check("b_rd_lat", 64'(t1), 64'd5);
        check("b_rd_rdata", 64'(rd1), 64'h5A);
        check("b_rd_addr_stable", 64'(bad), 64'd0);
        check("b_rd_no_we", 64'(we_seen), 64'd0);
        check("b_m0_rdata", 64'(b_m0_rdata), 64'd0);
        check("b_grant", 64'(b_grant), 64'd1);
        tick();
        check("b_idle", 64'(b_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
